// File: rtl/hada_pkg.sv
// Shared types and combinational abs/signum helpers for the hada unary datapath.
// hada_unary() dispatches on op and width and applies the result extension rules.
package hada;

    typedef enum logic [1:0] {
        HADA_ABS     = 2'd0,
        HADA_SIGNUM  = 2'd1,
        HADA_SIGNUMU = 2'd2,
        HADA_RSVD    = 2'd3
    } hada_op_e;

    typedef enum logic [1:0] {
        HADA_W8  = 2'd0,
        HADA_W16 = 2'd1,
        HADA_W32 = 2'd2,
        HADA_W64 = 2'd3
    } hada_width_e;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } hada_res_t;

    function automatic logic signed [63:0] hada_sext(input logic [63:0] x, input hada_width_e w);
        logic signed [63:0] r;
        case (w)
            HADA_W8:  r = signed'({{56{x[7]}},  x[7:0]});
            HADA_W16: r = signed'({{48{x[15]}}, x[15:0]});
            HADA_W32: r = signed'({{32{x[31]}}, x[31:0]});
            HADA_W64: r = signed'(x);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] hada_zext(input logic [63:0] x, input hada_width_e w);
        logic [63:0] r;
        case (w)
            HADA_W8:  r = {56'd0, x[7:0]};
            HADA_W16: r = {48'd0, x[15:0]};
            HADA_W32: r = {32'd0, x[31:0]};
            HADA_W64: r = x;
        endcase
        return r;
    endfunction

    // The most-negative operand negates to itself; re-extending keeps the wrap visible.
    function automatic logic [63:0] hada_abs(input logic [63:0] x, input hada_width_e w);
        logic signed [63:0] s;
        logic signed [63:0] m;
        s = hada_sext(x, w);
        m = (s < 0) ? -s : s;
        return unsigned'(hada_sext(unsigned'(m), w));
    endfunction

    function automatic logic [63:0] hada_signum(input logic [63:0] x, input hada_width_e w);
        logic signed [63:0] s;
        logic [63:0]        r;
        s = hada_sext(x, w);
        if (s < 0)
            r = '1;
        else if (s == 0)
            r = '0;
        else
            r = 64'd1;
        return r;
    endfunction

    function automatic logic [63:0] hada_signumu(input logic [63:0] x, input hada_width_e w);
        return (hada_zext(x, w) != 64'd0) ? 64'd1 : 64'd0;
    endfunction

    function automatic hada_res_t hada_unary(input hada_op_e op, input hada_width_e w,
                                             input longint unsigned x);
        hada_res_t r;
        r.err  = 1'b0;
        r.data = '0;
        case (op)
            HADA_ABS:     r.data = hada_abs(x, w);
            HADA_SIGNUM:  r.data = hada_signum(x, w);
            HADA_SIGNUMU: r.data = hada_signumu(x, w);
            HADA_RSVD:    r.err  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hada_rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, winner encode and one-hot grant.
// The pointer moves past the winner only on an accepted grant.
module hada_rr_arbiter import hada::*; #(
    parameter int N_REQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_valid,
    input  logic                     i_adv,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_fire
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] r_ptr;
    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic            w_fire;

    function automatic logic [ID_W-1:0] f_wrap(input int v);
        return (v >= N_REQ) ? ID_W'(v - N_REQ) : ID_W'(v);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_valid[f_wrap(int'(r_ptr) + k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    // Grant is suppressed while reset is asserted so nothing is accepted into a clearing pipe.
    assign w_fire = w_found && i_adv && i_rst_n;

    always_comb begin
        o_grant = '0;
        if (w_fire)
            o_grant[w_win] = 1'b1;
    end

    assign o_grant_id = w_win;
    assign o_fire     = w_fire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ptr <= '0;
        else if (w_fire)
            r_ptr <= f_wrap(int'(w_win) + 1);
    end

endmodule

// File: rtl/hada_unary_arbiter.sv
// Multi-requester front end for the hada abs/signum unit: round-robin admission
// into a two-stage registered pipeline with a single backpressured response port.
module hada_unary_arbiter import hada::*; #(
    parameter int N_REQ = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][1:0]       req_op,
    input  logic [N_REQ-1:0][1:0]       req_width,
    input  logic [N_REQ-1:0][63:0]      req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic [63:0]                 rsp_data,
    output logic                        rsp_err
);

    localparam int ID_W = $clog2(N_REQ);

    logic            w_adv;
    logic            w_fire;
    logic [ID_W-1:0] w_win;

    logic            r_vld_p1;
    logic [ID_W-1:0] r_id_p1;
    hada_op_e        r_op_p1;
    hada_width_e     r_width_p1;
    logic [63:0]     r_data_p1;
    hada_res_t       w_res_p1;

    logic            r_vld_p2;
    logic [ID_W-1:0] r_id_p2;
    logic [63:0]     r_data_p2;
    logic            r_err_p2;

    // Both stages move together; an unconsumed response freezes the whole pipe.
    assign w_adv = !r_vld_p2 || rsp_ready;

    hada_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (req_valid),
        .i_adv      (w_adv),
        .o_grant    (req_ready),
        .o_grant_id (w_win),
        .o_fire     (w_fire)
    );

    // Stage 1: capture the granted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vld_p1 <= 1'b0;
        else if (w_adv)
            r_vld_p1 <= w_fire;
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_id_p1    <= w_win;
            r_op_p1    <= hada_op_e'(req_op[w_win]);
            r_width_p1 <= hada_width_e'(req_width[w_win]);
            r_data_p1  <= req_data[w_win];
        end
    end

    assign w_res_p1 = hada_unary(r_op_p1, r_width_p1, r_data_p1);

    // Stage 2: registered response, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_id_p2   <= '0;
            r_data_p2 <= '0;
            r_err_p2  <= 1'b0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_id_p2   <= r_id_p1;
                r_data_p2 <= w_res_p1.data;
                r_err_p2  <= w_res_p1.err;
            end
        end
    end

    assign rsp_valid = r_vld_p2;
    assign rsp_id    = r_id_p2;
    assign rsp_data  = r_data_p2;
    assign rsp_err   = r_err_p2;

endmodule

// File: tb/tb_hada_unary_arbiter.sv
// Bench for hada_unary_arbiter: constant vector table, directed multi-cycle
// sequences and a randomized run against a queue-based reference model.
module tb_hada_unary_arbiter;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][1:0]   req_op;
    logic [N-1:0][1:0]   req_width;
    logic [N-1:0][63:0]  req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [63:0]         rsp_data;
    logic                rsp_err;

    always #5 clk = ~clk;

    hada_unary_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_width (req_width),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  w;
        logic [63:0] din;
        logic [63:0] dout;
        logic        err;
    } vec_t;

    exp_t        q[$];
    int          m_ptr = 0;
    int          n_acc = 0;
    logic        s_vld;
    logic [1:0]  s_id;
    logic [63:0] s_data;
    logic        s_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value of the low W bits as a W-bit two's-complement number.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [1:0] w,
                                          input logic [63:0] x, output logic err);
        int          bits;
        logic [63:0] mask, half, low, mag;
        bits = 8 << w;
        mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        half = 64'd1 << (bits - 1);
        low  = x & mask;
        err  = 1'b0;
        case (op)
            2'd0: begin
                mag = (low >= half) ? ((64'd0 - low) & mask) : low;
                return (mag >= half) ? (mag | ~mask) : mag;
            end
            2'd1: begin
                if (low == 64'd0) return 64'd0;
                if (low >= half)  return 64'hFFFF_FFFF_FFFF_FFFF;
                return 64'd1;
            end
            2'd2:    return (low != 64'd0) ? 64'd1 : 64'd0;
            default: begin err = 1'b1; return 64'd0; end
        endcase
    endfunction

    // One clock: at the falling edge predict grant, score responses; return at posedge+1.
    task automatic step(output int win);
        logic         adv;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        logic         er;
        int           idx;
        win = -1;
        @(negedge clk);
        s_vld  = rsp_valid;
        s_id   = rsp_id;
        s_data = rsp_data;
        s_err  = rsp_err;
        adv = !rsp_valid || rsp_ready;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        exp_rdy = '0;
        if (win >= 0 && adv) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (rsp_valid && rsp_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got id %0d with nothing outstanding", rsp_id);
            end else begin
                e = q.pop_front();
                total--;
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        if (win >= 0 && adv) begin
            e.id   = 2'(win);
            e.data = model(req_op[win], req_width[win], req_data[win], er);
            e.err  = er;
            q.push_back(e);
            m_ptr = (win + 1) % N;
            n_acc++;
        end else begin
            win = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        q.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int w;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) step(w);
        chk("drain_left", 64'(q.size()), 64'd0);
        step(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[15];
        int   w;
        int   id;
        logic [63:0] hold_data;
        logic [1:0]  hold_id;
        logic        hold_err;

        vt[0]  = '{2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FF85, 64'h0000_0000_0000_007B, 1'b0};
        vt[1]  = '{2'd0, 2'd0, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vt[2]  = '{2'd1, 2'd2, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[3]  = '{2'd2, 2'd1, 64'h0000_0000_00AB_0000, 64'h0, 1'b0};
        vt[4]  = '{2'd1, 2'd3, 64'h0, 64'h0, 1'b0};
        vt[5]  = '{2'd3, 2'd0, 64'h0000_0000_0000_0012, 64'h0, 1'b1};
        vt[6]  = '{2'd0, 2'd1, 64'h0000_0000_0001_7FFF, 64'h0000_0000_0000_7FFF, 1'b0};
        vt[7]  = '{2'd0, 2'd2, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0};
        vt[8]  = '{2'd0, 2'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
        vt[9]  = '{2'd1, 2'd1, 64'h0000_0000_0000_1234, 64'h1, 1'b0};
        vt[10] = '{2'd2, 2'd3, 64'h8000_0000_0000_0000, 64'h1, 1'b0};
        vt[11] = '{2'd1, 2'd0, 64'h0000_0000_0000_FF00, 64'h0, 1'b0};
        vt[12] = '{2'd0, 2'd2, 64'hDEAD_0000_0000_0005, 64'h5, 1'b0};
        vt[13] = '{2'd2, 2'd0, 64'h0000_0000_0000_0100, 64'h0, 1'b0};
        vt[14] = '{2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_7FFF, 1'b0};

        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_width = '0; req_data = '0;
        #12;
        req_valid = '1;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // constant table, one requester at a time, two-cycle latency
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            id = i % N;
            rsp_ready     = 1'b1;
            req_op[id]    = vt[i].op;
            req_width[id] = vt[i].w;
            req_data[id]  = vt[i].din;
            req_valid     = '0;
            req_valid[id] = 1'b1;
            @(negedge clk);
            chk("tbl_ready", 64'(req_ready), 64'(1 << id));
            @(posedge clk);
            #1;
            req_valid = '0;
            @(negedge clk);
            chk("tbl_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            chk("tbl_valid", 64'(rsp_valid), 64'd1);
            chk("tbl_id", 64'(rsp_id), 64'(id));
            chk("tbl_data", rsp_data, vt[i].dout);
            chk("tbl_err", 64'(rsp_err), 64'(vt[i].err));
        end
        @(posedge clk);
        #1;

        // all requesters valid: strict rotation, one response per cycle
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op[i] = 2'd0; req_width[i] = 2'd0; req_data[i] = 64'(8'hF0 + i);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step(w);
            chk("rr_grant", 64'(w), 64'(c % N));
            if (c >= 2) begin
                chk("rr_vld", 64'(s_vld), 64'd1);
                chk("rr_id", 64'(s_id), 64'((c - 2) % N));
            end
        end
        drain();

        // stall: three requesters, consumer blocked five cycles
        do_reset();
        req_valid = 4'b0111;
        rsp_ready = 1'b0;
        n_acc = 0;
        hold_id = '0; hold_data = '0; hold_err = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(w);
            if (c == 2) begin
                chk("stall_vld", 64'(s_vld), 64'd1);
                hold_id = s_id; hold_data = s_data; hold_err = s_err;
            end
            if (c > 2) begin
                chk("stall_id_hold", 64'(s_id), 64'(hold_id));
                chk("stall_data_hold", s_data, hold_data);
                chk("stall_err_hold", 64'(s_err), 64'(hold_err));
            end
        end
        chk("stall_accepts", 64'(n_acc), 64'd2);
        drain();

        // reserved op from requester 2, then a normal request
        do_reset();
        rsp_ready = 1'b1;
        req_op[2] = 2'd3; req_width[2] = 2'd1; req_data[2] = 64'h1234;
        req_op[0] = 2'd0; req_width[0] = 2'd0; req_data[0] = 64'hFB;
        req_valid = 4'b0100;
        step(w);
        chk("rsvd_grant", 64'(w), 64'd2);
        req_valid = 4'b0001;
        step(w);
        req_valid = '0;
        step(w);
        chk("rsvd_id", 64'(s_id), 64'd2);
        chk("rsvd_err", 64'(s_err), 64'd1);
        chk("rsvd_data", s_data, 64'd0);
        step(w);
        chk("after_rsvd_err", 64'(s_err), 64'd0);
        chk("after_rsvd_data", s_data, 64'd5);
        drain();

        // reset with both stages occupied
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b0;
        step(w);
        step(w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        m_ptr = 0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b0110;
        #1;
        chk("postrst_ready", 64'(req_ready), 64'b0010);
        step(w);
        chk("postrst_grant", 64'(w), 64'd1);
        drain();

        // randomized traffic against the reference queue
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 9) < 5) begin
                    req_op[i]    = 2'($urandom_range(0, 3));
                    req_width[i] = 2'($urandom_range(0, 3));
                    req_data[i]  = {$urandom, $urandom};
                    req_valid[i] = 1'b1;
                end
            end
            step(w);
            if (w >= 0) req_valid[w] = 1'b0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
